// File: rtl/player_input_capture.sv
// -----------------------------------------------------------------------------
// player_input_capture
//
// Collects the player's answer one digit at a time. The digit is set on four
// switches and committed with an active-low pushbutton. The button is
// synchronised and debounced on both edges. Each press emits exactly one
// validated digit with its position in the sequence. A one-cycle done pulse
// follows once the release of the last expected digit has been debounced.
//
// Optional feature, macro PLAYER_INPUT_ECHO_EN:
//   Defining the macro adds echo_num_o / no_echo_num_o. These outputs drive the
//   leftmost display with the synchronised switch value while the player is
//   choosing a digit, so the digit is visible before it is committed.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   start_entry_i  one-cycle pulse, arms a new entry from any state
//   seq_length_i   number of digits expected (latched on start, clamped)
//   switches_i     raw digit value, sampled only at commit
//   key_n_i        raw enter button, active-low, asynchronous to clk_i
//   digit_valid_o  one-cycle pulse per committed digit
//   digit_out_o    committed digit, held until the next commit
//   digit_index_o  0-based position of digit_out_o in the sequence
//   bad_digit_o    qualifies digit_valid_o: committed value > 9
//   entry_busy_o   high while an entry is in progress
//   entry_done_o   one-cycle pulse when the last release is debounced
//   echo_num_o     (echo build) synchronised switches while choosing a digit
//   no_echo_num_o  (echo build) blanks the echo display when high
// -----------------------------------------------------------------------------
module player_input_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_LEN         = 8,
  parameter int CNT_W           = 19
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_entry_i,
  input  logic [3:0] seq_length_i,
  input  logic [3:0] switches_i,
  input  logic       key_n_i,
  output logic       digit_valid_o,
  output logic [3:0] digit_out_o,
  output logic [3:0] digit_index_o,
  output logic       bad_digit_o,
  output logic       entry_busy_o,
  output logic       entry_done_o
`ifdef PLAYER_INPUT_ECHO_EN
  ,
  output logic [3:0] echo_num_o,
  output logic       no_echo_num_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_DEB_DN = 3'd2,
    ST_HELD   = 3'd3,
    ST_DEB_UP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       MAX_LEN_C = 4'(MAX_LEN);

  // Requested lengths beyond MAX_LEN are clamped to MAX_LEN.
  function automatic logic [3:0] clamp_len(input logic [3:0] req);
    logic [3:0] res;
    if (req > MAX_LEN_C) begin
      res = MAX_LEN_C;
    end else begin
      res = req;
    end
    return res;
  endfunction

  // Synchroniser stages; both idle at the released (high) level.
  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic             press_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       start_len_s;

  logic             digit_valid_q, digit_valid_d;
  logic [3:0]       digit_out_q, digit_out_d;
  logic [3:0]       digit_index_q, digit_index_d;
  logic             bad_digit_q, bad_digit_d;
  logic             entry_busy_q, entry_busy_d;
  logic             entry_done_q, entry_done_d;

`ifdef PLAYER_INPUT_ECHO_EN
  logic [3:0]       sw_meta_q, sw_meta_d;
  logic [3:0]       echo_num_q, echo_num_d;
  logic             no_echo_num_q, no_echo_num_d;
  logic             echo_on_s;
`endif

  assign press_s     = ~key_sync_q;
  assign start_len_s = clamp_len(seq_length_i);

  // Next-state and next-output logic for the synchroniser and entry FSM.
  always_comb begin
    key_meta_d    = key_n_i;
    key_sync_d    = key_meta_q;
    state_d       = state_q;
    deb_cnt_d     = deb_cnt_q;
    count_d       = count_q;
    len_d         = len_q;
    digit_valid_d = 1'b0;
    digit_out_d   = digit_out_q;
    digit_index_d = digit_index_q;
    bad_digit_d   = bad_digit_q;

    if (start_entry_i) begin
      // A new entry overrides whatever the FSM was doing this cycle.
      len_d     = start_len_s;
      count_d   = 4'd0;
      deb_cnt_d = CNT_ZERO;
      if (start_len_s == 4'd0) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_ARMED;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ARMED: begin
          if (press_s) begin
            state_d   = ST_DEB_DN;
            deb_cnt_d = CNT_ZERO;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_DEB_DN: begin
          if (!press_s) begin
            state_d = ST_ARMED;
          end else if (deb_cnt_q == DEB_LAST) begin
            // Press is stable: commit the digit exactly once.
            state_d       = ST_HELD;
            digit_valid_d = 1'b1;
            digit_out_d   = switches_i;
            digit_index_d = count_q;
            bad_digit_d   = (switches_i > 4'd9);
            count_d       = count_q + 4'd1;
          end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!press_s) begin
            state_d   = ST_DEB_UP;
            deb_cnt_d = CNT_ZERO;
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_DEB_UP: begin
          if (press_s) begin
            // Bounce on release: back to held, no new digit.
            state_d = ST_HELD;
          end else if (deb_cnt_q == DEB_LAST) begin
            if (count_q == len_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    entry_busy_d = (state_d == ST_ARMED) || (state_d == ST_DEB_DN) ||
                   (state_d == ST_HELD)  || (state_d == ST_DEB_UP);
    entry_done_d = (state_d == ST_DONE);

`ifdef PLAYER_INPUT_ECHO_EN
    // echo_num_q acts as the second synchroniser stage for the switches.
    sw_meta_d = switches_i;
    echo_on_s = (state_d == ST_ARMED) || (state_d == ST_DEB_DN) ||
                (state_d == ST_HELD);
    if (echo_on_s) begin
      echo_num_d = sw_meta_q;
    end else begin
      echo_num_d = 4'd0;
    end
    no_echo_num_d = ~echo_on_s;
`endif
  end

  // State, counter and registered-output flops with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_meta_q    <= 1'b1;
      key_sync_q    <= 1'b1;
      state_q       <= ST_IDLE;
      deb_cnt_q     <= CNT_ZERO;
      count_q       <= 4'd0;
      len_q         <= 4'd0;
      digit_valid_q <= 1'b0;
      digit_out_q   <= 4'd0;
      digit_index_q <= 4'd0;
      bad_digit_q   <= 1'b0;
      entry_busy_q  <= 1'b0;
      entry_done_q  <= 1'b0;
`ifdef PLAYER_INPUT_ECHO_EN
      sw_meta_q     <= 4'd0;
      echo_num_q    <= 4'd0;
      no_echo_num_q <= 1'b1;
`endif
    end else begin
      key_meta_q    <= key_meta_d;
      key_sync_q    <= key_sync_d;
      state_q       <= state_d;
      deb_cnt_q     <= deb_cnt_d;
      count_q       <= count_d;
      len_q         <= len_d;
      digit_valid_q <= digit_valid_d;
      digit_out_q   <= digit_out_d;
      digit_index_q <= digit_index_d;
      bad_digit_q   <= bad_digit_d;
      entry_busy_q  <= entry_busy_d;
      entry_done_q  <= entry_done_d;
`ifdef PLAYER_INPUT_ECHO_EN
      sw_meta_q     <= sw_meta_d;
      echo_num_q    <= echo_num_d;
      no_echo_num_q <= no_echo_num_d;
`endif
    end
  end

  assign digit_valid_o = digit_valid_q;
  assign digit_out_o   = digit_out_q;
  assign digit_index_o = digit_index_q;
  assign bad_digit_o   = bad_digit_q;
  assign entry_busy_o  = entry_busy_q;
  assign entry_done_o  = entry_done_q;
`ifdef PLAYER_INPUT_ECHO_EN
  assign echo_num_o    = echo_num_q;
  assign no_echo_num_o = no_echo_num_q;
`endif

endmodule

// File: tb/tb_player_input_capture.sv
// -----------------------------------------------------------------------------
// Bench for player_input_capture with DEBOUNCE_CYCLES=4, MAX_LEN=8.
// The reference model tracks entry progress as run lengths of the synchronised
// press level. A press or release is accepted after DEBOUNCE_CYCLES+1
// consecutive samples at the new level. The model is compared with the DUT
// after every clock edge. Directed scenarios pin digit/index values and pulse
// timing with literal values, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_player_input_capture;

  localparam int DEB  = 4;
  localparam int MAXL = 8;

  logic       clk;
  logic       rst;
  logic       start_entry;
  logic [3:0] seq_length;
  logic [3:0] switches;
  logic       key_n;
  logic       digit_valid;
  logic [3:0] digit_out;
  logic [3:0] digit_index;
  logic       bad_digit;
  logic       entry_busy;
  logic       entry_done;
`ifdef PLAYER_INPUT_ECHO_EN
  logic [3:0] echo_num;
  logic       no_echo_num;
`endif

  player_input_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_LEN        (MAXL),
    .CNT_W          (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_entry_i(start_entry),
    .seq_length_i (seq_length),
    .switches_i   (switches),
    .key_n_i      (key_n),
    .digit_valid_o(digit_valid),
    .digit_out_o  (digit_out),
    .digit_index_o(digit_index),
    .bad_digit_o  (bad_digit),
    .entry_busy_o (entry_busy),
    .entry_done_o (entry_done)
`ifdef PLAYER_INPUT_ECHO_EN
    ,
    .echo_num_o   (echo_num),
    .no_echo_num_o(no_echo_num)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model phases: idle, waiting for a press, waiting for a release, done.
  localparam int P_IDLE = 0;
  localparam int P_WAITP = 1;
  localparam int P_WAITR = 2;
  localparam int P_DONE = 3;

  int m_ph = P_IDLE;
  int m_run = 0;
  int m_cnt = 0;
  int m_len = 0;
  int m_key[2] = '{1, 1};
  int m_sw[2] = '{0, 0};
  int e_valid = 0, e_dig = 0, e_idx = 0, e_bad = 0, e_busy = 0, e_done = 0;
  int e_echo_on = 0;

  // Observation bookkeeping for literal checks.
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_seen = 0;
  int log_q[$];

  function automatic int log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return -1;
  endfunction

  // Model update and DUT comparison after every rising edge.
  always @(posedge clk) begin
    int press;
    cyc++;
    press = (m_key[1] == 0) ? 1 : 0;
    e_valid = 0;
    e_done  = 0;
    if (rst) begin
      m_ph = P_IDLE; m_run = 0; m_cnt = 0; m_len = 0;
      m_key[0] = 1; m_key[1] = 1; m_sw[0] = 0; m_sw[1] = 0;
      e_dig = 0; e_idx = 0; e_bad = 0;
    end else begin
      m_key[1] = m_key[0]; m_key[0] = int'(key_n);
      m_sw[1] = m_sw[0];   m_sw[0] = int'(switches);
      if (start_entry) begin
        m_len = (int'(seq_length) > MAXL) ? MAXL : int'(seq_length);
        m_cnt = 0;
        m_run = 0;
        if (m_len == 0) begin
          m_ph = P_DONE;
          e_done = 1;
        end else begin
          m_ph = P_WAITP;
        end
      end else if (m_ph == P_DONE) begin
        m_ph = P_IDLE;
      end else if (m_ph == P_WAITP) begin
        if (press == 1) begin
          m_run++;
          if (m_run == DEB + 1) begin
            e_valid = 1; e_dig = int'(switches); e_idx = m_cnt;
            e_bad = (int'(switches) > 9) ? 1 : 0;
            m_cnt++; m_ph = P_WAITR; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (m_ph == P_WAITR) begin
        if (press == 0) begin
          m_run++;
          if (m_run == DEB + 1) begin
            m_run = 0;
            if (m_cnt == m_len) begin
              m_ph = P_DONE;
              e_done = 1;
            end else begin
              m_ph = P_WAITP;
            end
          end
        end else begin
          m_run = 0;
        end
      end
    end
    e_busy = (m_ph == P_WAITP || m_ph == P_WAITR) ? 1 : 0;
    // Echo is live while choosing or holding, but not while release debounces.
    e_echo_on = (m_ph == P_WAITP || (m_ph == P_WAITR && m_run == 0)) ? 1 : 0;
    #1;
    chk("digit_valid", int'(digit_valid), e_valid);
    chk("digit_out", int'(digit_out), e_dig);
    chk("digit_index", int'(digit_index), e_idx);
    chk("bad_digit", int'(bad_digit), e_bad);
    chk("entry_busy", int'(entry_busy), e_busy);
    chk("entry_done", int'(entry_done), e_done);
`ifdef PLAYER_INPUT_ECHO_EN
    chk("echo_num", int'(echo_num), (e_echo_on == 1) ? m_sw[1] : 0);
    chk("no_echo_num", int'(no_echo_num), 1 - e_echo_on);
`endif
    if (digit_valid) log_q.push_back(int'(bad_digit) * 256 + int'(digit_out) * 16 + int'(digit_index));
    if (entry_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (entry_busy) busy_seen = 1;
  end

  int rel_cyc = 0;
  int st_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int len);
    start_entry = 1'b1;
    seq_length  = 4'(len);
    st_cyc      = cyc;
    tick(1);
    start_entry = 1'b0;
  endtask

  task automatic press(input int sw, input int hold, input int rel);
    switches = 4'(sw);
    key_n    = 1'b0;
    tick(hold);
    key_n    = 1'b1;
    rel_cyc  = cyc;
    tick(rel);
  endtask

  task automatic clear_obs();
    log_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    busy_seen = 0;
  endtask

  initial begin
    rst = 1'b1; start_entry = 1'b0; seq_length = 4'd0; switches = 4'd0; key_n = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("reset_busy", int'(entry_busy), 0);
    chk("reset_done", int'(entry_done), 0);
    chk("reset_valid", int'(digit_valid), 0);
    chk("reset_digit", int'(digit_out), 0);
    tick(2);

    // 1: three clean presses 5, 2, 9 with length 3.
    clear_obs();
    start(3);
    press(5, 10, 10);
    press(2, 10, 10);
    press(9, 10, 10);
    chk("t1_ndig", log_q.size(), 3);
    chk("t1_d0", log_at(0), 8'h50);
    chk("t1_d1", log_at(1), 8'h21);
    chk("t1_d2", log_at(2), 8'h92);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_lat", done_cyc - rel_cyc, 7);

    // 2: two-cycle glitch rejected, then digit 7 at index 0.
    clear_obs();
    start(1);
    press(7, 2, 10);
    chk("t2_glitch_ndig", log_q.size(), 0);
    chk("t2_still_armed", int'(entry_busy), 1);
    press(7, 10, 10);
    chk("t2_d0", log_at(0), 8'h70);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: out-of-range digit 12 is flagged but still counts.
    clear_obs();
    start(1);
    press(12, 10, 10);
    chk("t3_d0", log_at(0), 256 + 12 * 16);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: long hold with a one-cycle release blip.
    clear_obs();
    start(1);
    switches = 4'd4; key_n = 1'b0;
    tick(50);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(49);
    chk("t4_no_done_yet", done_cnt, 0);
    key_n = 1'b1; tick(15);
    chk("t4_ndig", log_q.size(), 1);
    chk("t4_done_cnt", done_cnt, 1);

    // 5a: zero length finishes immediately without going busy.
    clear_obs();
    start(0);
    tick(3);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_done_cyc", done_cyc - st_cyc, 1);
    chk("t5_busy_seen", busy_seen, 0);

    // 5b: length 15 is clamped to 8.
    clear_obs();
    start(15);
    for (int i = 0; i < 7; i++) press((i * 3) % 10, 10, 10);
    chk("t5_ndig7", log_q.size(), 7);
    chk("t5_no_early_done", done_cnt, 0);
    press(1, 10, 10);
    chk("t5_last", log_at(7), 8'h17);
    chk("t5b_done_cnt", done_cnt, 1);

    // 6: reset mid-entry, then a fresh two-digit entry.
    clear_obs();
    start(3);
    press(8, 10, 10);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(20);
    chk("t6_no_stale_done", done_cnt, 0);
`ifdef PLAYER_INPUT_ECHO_EN
    chk("t6_noecho_idle", int'(no_echo_num), 1);
`endif
    clear_obs();
    switches = 4'd3;
    start(2);
    tick(3);
`ifdef PLAYER_INPUT_ECHO_EN
    chk("t6_noecho_armed", int'(no_echo_num), 0);
    chk("t6_echo3", int'(echo_num), 3);
    switches = 4'd6;
    tick(1);
    chk("t6_echo_lag", int'(echo_num), 3);
    tick(1);
    chk("t6_echo6", int'(echo_num), 6);
`endif
    press(6, 10, 10);
    press(1, 10, 10);
    chk("t6_d0", log_at(0), 8'h60);
    chk("t6_d1", log_at(1), 8'h11);
    chk("t6_done_cnt", done_cnt, 1);

    // Randomized phase: bouncy button, random digits, restarts and resets.
    for (int it = 0; it < 600; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        start(int'($urandom_range(0, 15)));
      end else if (r < 7) begin
        rst = 1'b1;
        tick(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end else begin
        switches = 4'($urandom_range(0, 15));
        key_n    = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
        tick(int'($urandom_range(1, 9)));
      end
    end
    key_n = 1'b1;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
